// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with flush, almost flags and dout hold.
// Ports: clk, reset_n (async, active-low), flush, wr_en/din, rd_en/dout,
//        data_count, full, empty, almost_full, almost_empty,
//        wr_ack, wr_err, rd_ack, rd_err (one-cycle status pulses).
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter bit HOLD_DOUT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L =
    (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L =
    (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    (ADDR_WIDTH)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] head, head_nxt;
  logic [ADDR_WIDTH-1:0] tail, tail_nxt;
  logic [ADDR_WIDTH:0]   count, count_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;

  logic rd_ok;
  logic wr_ok;

  assign full         = (count == CNT_MAX);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);
  assign data_count   = count;

  // A write into a full FIFO is allowed only when the same-cycle read
  // frees the slot; the read returns the old word at head.
  assign rd_ok = rd_en & ~flush & ~empty;
  assign wr_ok = wr_en & ~flush & (~full | rd_ok);

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    dout_nxt  = HOLD_DOUT ? dout : '0;
    if (flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
      dout_nxt  = '0;
    end else begin
      if (rd_ok) begin
        head_nxt = head + PTR_ONE;
        dout_nxt = mem[head];
      end
      if (wr_ok) begin
        tail_nxt = tail + PTR_ONE;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      dout   <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      head   <= head_nxt;
      tail   <= tail_nxt;
      count  <= count_nxt;
      dout   <= dout_nxt;
      wr_ack <= wr_ok;
      wr_err <= wr_en & ~flush & ~wr_ok;
      rd_ack <= rd_ok;
      rd_err <= rd_en & ~flush & ~rd_ok;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table vectors, hand sequences and random traffic
// against a queue-based reference model of fifo_param.
module tb_fifo_param;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic [AW:0]   data_count;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_ack, wr_err, rd_ack, rd_err;

  logic          h_rst_n;
  logic          h_flush;
  logic          h_wr;
  logic [DW-1:0] h_din;
  logic          h_rd;
  logic [DW-1:0] h_dout;
  logic [AW:0]   h_count;
  logic          h_full, h_empty, h_af, h_ae;
  logic          h_wack, h_werr, h_rack, h_rerr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_wack, m_werr, m_rack, m_rerr;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] d;
    logic [31:0] e_dout;
    int          e_cnt;
    bit          e_wack;
    bit          e_werr;
    bit          e_rack;
    bit          e_rerr;
    bit          e_full;
    bit          e_empty;
    bit          e_af;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .AF_LEVEL(6), .AE_LEVEL(1), .HOLD_DOUT(1'b0)
  ) u_dut (
    .clk(clk), .reset_n(rst_n), .flush(flush),
    .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .data_count(data_count),
    .full(full), .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .AF_LEVEL(6), .AE_LEVEL(1), .HOLD_DOUT(1'b1)
  ) u_hold (
    .clk(clk), .reset_n(h_rst_n), .flush(h_flush),
    .wr_en(h_wr), .din(h_din), .rd_en(h_rd),
    .dout(h_dout), .data_count(h_count),
    .full(h_full), .empty(h_empty),
    .almost_full(h_af), .almost_empty(h_ae),
    .wr_ack(h_wack), .wr_err(h_werr),
    .rd_ack(h_rack), .rd_err(h_rerr)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_wack = 1'b0;
    m_werr = 1'b0;
    m_rack = 1'b0;
    m_rerr = 1'b0;
  endtask

  task automatic model_cycle();
    bit rok, wok;
    if (flush) begin
      model_reset();
    end else begin
      rok = rd_en && (q.size() > 0);
      wok = wr_en && ((q.size() < DEPTH) || rok);
      if (rok) m_dout = q.pop_front();
      else     m_dout = '0;
      if (wok) q.push_back(din);
      m_wack = wok;
      m_werr = wr_en && !wok;
      m_rack = rok;
      m_rerr = rd_en && !rok;
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".dout"},  dout, m_dout);
    chk({tag, ".count"}, 32'(data_count), n);
    chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(n >= 6));
    chk({tag, ".ae"},    32'(almost_empty), 32'(n <= 1));
    chk({tag, ".wack"},  32'(wr_ack), 32'(m_wack));
    chk({tag, ".werr"},  32'(wr_err), 32'(m_werr));
    chk({tag, ".rack"},  32'(rd_ack), 32'(m_rack));
    chk({tag, ".rerr"},  32'(rd_err), 32'(m_rerr));
  endtask

  task automatic set_in(input bit f, input bit w,
                        input logic [31:0] d, input bit r);
    flush = f;
    wr_en = w;
    din   = d;
    rd_en = r;
  endtask

  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    h_rst_n = 1'b0;
    h_flush = 1'b0;
    h_wr    = 1'b0;
    h_din   = '0;
    h_rd    = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();

    for (int i = 0; i < 9; i++) begin
      vecs[i] = '{wr: 1, rd: 0, d: 32'h11 * (i + 1),
                  e_dout: 0,
                  e_cnt: (i < 8) ? i + 1 : 8,
                  e_wack: (i < 8), e_werr: (i == 8),
                  e_rack: 0, e_rerr: 0,
                  e_full: (i >= 7), e_empty: 0,
                  e_af: (i >= 5)};
    end
    for (int i = 0; i < 9; i++) begin
      vecs[9+i] = '{wr: 0, rd: 1, d: 0,
                    e_dout: (i < 8) ? 32'h11 * (i + 1) : 0,
                    e_cnt: (i < 8) ? 7 - i : 0,
                    e_wack: 0, e_werr: 0,
                    e_rack: (i < 8), e_rerr: (i == 8),
                    e_full: 0, e_empty: (i >= 7),
                    e_af: (i < 2)};
    end

    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    chk("h_reset.dout",  h_dout, 0);
    chk("h_reset.empty", 32'(h_empty), 1);
    rst_n   = 1'b1;
    h_rst_n = 1'b1;

    // Tests 1 and 2: fill, overflow, drain, underflow.
    for (int i = 0; i < 18; i++) begin
      set_in(0, vecs[i].wr, vecs[i].d, vecs[i].rd);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.dout", i),
          dout, vecs[i].e_dout);
      chk($sformatf("vec%0d.count", i),
          32'(data_count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.acks", i),
          {28'd0, wr_ack, wr_err, rd_ack, rd_err},
          {28'd0, vecs[i].e_wack, vecs[i].e_werr,
           vecs[i].e_rack, vecs[i].e_rerr});
      chk($sformatf("vec%0d.flags", i),
          {29'd0, full, empty, almost_full},
          {29'd0, vecs[i].e_full, vecs[i].e_empty,
           vecs[i].e_af});
    end

    // Test 3: wrap-around.
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 32'h200 + i, 0);
      step("wrap_w5");
    end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1);
      step("wrap_r5");
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h300 + i, 0);
      step("wrap_w8");
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 1);
      step("wrap_r8");
      chk("wrap_r8.data", dout, 32'h300 + i);
    end

    // Test 4: simultaneous read and write while full.
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h101 + i, 0);
      step("t4_fill");
    end
    set_in(0, 1, 32'hAA, 1);
    step("t4_rw");
    chk("t4_rw.dout", dout, 32'h101);
    chk("t4_rw.count", 32'(data_count), 8);
    chk("t4_rw.acks", {30'd0, wr_ack, rd_ack}, 3);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 1);
      step("t4_drain");
    end
    chk("t4_last", dout, 32'hAA);
    chk("t4_empty", 32'(empty), 1);

    // Test 5: read+write on empty, no bypass.
    set_in(0, 1, 32'h55, 1);
    step("t5_rw");
    chk("t5.wack", 32'(wr_ack), 1);
    chk("t5.rerr", 32'(rd_err), 1);
    chk("t5.count", 32'(data_count), 1);
    set_in(0, 0, 0, 1);
    step("t5_rd");
    chk("t5.dout", dout, 32'h55);

    // Test 6a: flush beats concurrent read and write.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 32'h400 + i, 0);
      step("t6_fill");
    end
    set_in(1, 1, 32'h77, 1);
    step("t6_flush");
    chk("t6.count", 32'(data_count), 0);
    chk("t6.empty", 32'(empty), 1);
    chk("t6.acks",
        {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 31) == 0),
             $urandom_range(0, 1), $urandom,
             $urandom_range(0, 1));
      step("rand");
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 32'h500 + i, 0);
      step("mid_fill");
    end
    set_in(0, 0, 0, 1);
    step("mid_rd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("mid_rst");
    #1;
    rst_n = 1'b1;
    set_in(0, 0, 0, 1);
    step("mid_after");

    // Test 6b: hold mode keeps the last read word.
    set_in(0, 0, 0, 0);
    h_wr  = 1'b1;
    h_din = 32'hCC;
    step("h_wr");
    h_wr = 1'b0;
    h_rd = 1'b1;
    step("h_rd");
    chk("h_rd.dout", h_dout, 32'hCC);
    chk("h_rd.rack", 32'(h_rack), 1);
    h_rd = 1'b0;
    repeat (3) step("h_idle");
    chk("h_idle.dout", h_dout, 32'hCC);
    chk("h_idle.rack", 32'(h_rack), 0);
    h_rd = 1'b1;
    step("h_under");
    chk("h_under.dout", h_dout, 32'hCC);
    chk("h_under.rerr", 32'(h_rerr), 1);
    h_rd = 1'b0;
    h_wr = 1'b1;
    h_din = 32'hDD;
    step("h_wr2");
    h_wr = 1'b0;
    h_flush = 1'b1;
    step("h_flush");
    chk("h_flush.dout", h_dout, 0);
    chk("h_flush.count", 32'(h_count), 0);
    h_flush = 1'b0;
    h_wr = 1'b1;
    h_din = 32'hEE;
    step("h_wr3");
    h_wr = 1'b0;
    h_rd = 1'b1;
    step("h_rd3");
    chk("h_rd3.dout", h_dout, 32'hEE);
    h_rd = 1'b0;
    h_wr = 1'b1;
    h_din = 32'hFF;
    step("h_wr4");
    h_wr = 1'b0;
    #2;
    h_rst_n = 1'b0;
    #1;
    chk("h_rst.dout", h_dout, 0);
    chk("h_rst.count", 32'(h_count), 0);
    chk("h_rst.empty", 32'(h_empty), 1);
    #1;
    h_rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 8-deep × 32-bit FIFO.
- Generalised in data width and depth. Adds:
  - synchronous flush;
  - programmable almost-full / almost-empty flags;
  - a dout hold mode;
  - defined simultaneous read+write when full.
- Sits between producer/consumer datapath blocks; storage is an internal register array, not an external RAM.

Parameters:
DATA_WIDTH, 32, width of din/dout.
ADDR_WIDTH, 3, pointer width; DEPTH = 2^ADDR_WIDTH entries.
AF_LEVEL, 6, almost_full asserted when data_count >= AF_LEVEL (legal range 1..DEPTH).
AE_LEVEL, 1, almost_empty asserted when data_count <= AE_LEVEL (legal range 0..DEPTH-1).
HOLD_DOUT, 0, 0: dout returns to zero on cycles without a successful read; 1: dout holds the last read word.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO contents; highest priority.
wr_en  input  1  write request.
din  input  DATA_WIDTH  write data.
rd_en  input  1  read request.
dout  output  DATA_WIDTH  registered read data.
data_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
full  output  1  data_count == DEPTH.
empty  output  1  data_count == 0.
almost_full  output  1  data_count >= AF_LEVEL.
almost_empty  output  1  data_count <= AE_LEVEL.
wr_ack  output  1  previous-cycle write accepted.
wr_err  output  1  previous-cycle write rejected.
rd_ack  output  1  previous-cycle read accepted.
rd_err  output  1  previous-cycle read rejected.

Behaviour:
- Clock and reset:
  - One clock domain, `clk`.
  - `reset_n` is asynchronous and active-low.
  - While `reset_n` = 0: head = tail = 0, data_count = 0, dout = 0, all ack/err = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0).
  - Storage array contents are not reset.
- Flags:
  - full, empty, almost_full, almost_empty are combinational decodes of the registered data_count.
  - All four change in the cycle after the causing edge.
- Write acceptance: accepted at a rising edge when wr_en = 1, flush = 0, and either full = 0 or (full = 1 and the read is accepted in the same cycle).
  - Accepted: mem[tail] <= din; tail <= tail + 1 (wraps modulo DEPTH); wr_ack = 1 next cycle.
  - Rejected (wr_en = 1 but not accepted, flush = 0): wr_err = 1 next cycle; no state change.
- Read acceptance: accepted when rd_en = 1, flush = 0, empty = 0.
  - dout <= mem[head]; head <= head + 1 (wraps); rd_ack = 1 next cycle.
  - Latency: data appears on dout 1 cycle after the accepting edge.
  - Rejected (rd_en = 1, empty = 1): rd_err = 1 next cycle.
  - Cycles without an accepted read: dout <= 0 if HOLD_DOUT = 0; dout unchanged if HOLD_DOUT = 1.
- No write-through bypass: a write to an empty FIFO is not readable in the same cycle. rd+wr when empty gives wr_ack, rd_err, count 1.
- Simultaneous accepted read and write: data_count unchanged; both pointers advance.
  - This includes the full case: the read frees the slot being written; head == tail is legal since the read returns the old word.
- data_count next value:
  - +1 for write only;
  - -1 for read only;
  - unchanged otherwise.
  - Never exceeds DEPTH; never goes below 0.
- Flush (flush = 1 at an edge):
  - head, tail, data_count <= 0.
  - dout <= 0 regardless of HOLD_DOUT.
  - All ack/err <= 0.
  - rd_en/wr_en in that cycle are ignored, with no err reported.
- Ack/err pulse rules:
  - Each ack/err is a single-cycle pulse per request cycle.
  - wr_ack and wr_err are never both 1; rd_ack and rd_err are never both 1.
- Reset mid-operation: immediate return to the reset state. Stored words are not retrievable afterwards (count = 0).
- Implementation structure: state held in pointer registers and a count register; next-state and flag logic are combinational.

Test Plan:
Defaults used throughout (32-bit, depth 8, AF = 6, AE = 1, HOLD_DOUT = 0).
1. Reset, then 8 writes of 0x11..0x88 → wr_ack each cycle; data_count ends at 8; almost_full rises after the 6th write; full = 1 after the 8th. A 9th write 0x99 → wr_err = 1, count stays 8.
2. From full, 8 reads → dout = 0x11..0x88 in order, each 1 cycle after the request; rd_ack pulses; empty = 1 after the last read. A 9th read → rd_err = 1, dout = 0.
3. Wrap-around: write 5, read 5, write 8, read 8 → data returned in order across the pointer wrap; data_count correct every cycle.
4. Full with rd_en = wr_en = 1 writing 0xAA → rd_ack and wr_ack both pulse; count stays 8; dout = oldest word. After 7 further reads, the 8th read returns 0xAA.
5. Empty with rd_en = wr_en = 1 writing 0x55 → wr_ack = 1, rd_err = 1, count = 1. The next read returns 0x55.
6. Flush with 4 entries stored while rd_en = wr_en = 1 → count = 0, empty = 1, no ack/err. With HOLD_DOUT = 1, a read of 0xCC followed by idle cycles keeps dout = 0xCC; asserting reset_n = 0 mid-stream clears dout and count asynchronously.
